regfile_alu_seq: RTL and testbench
==================================

# regfile_alu_seq

Four-phase sequencer for the register-file/ALU datapath. Accepts one operation command (ALU op, two read addresses, write address, write-back flag) over a valid/ready handshake. From a single clock it produces the one-cycle stage strobes for operand read (A/B latch), result/flag latch (F/FR) and register write-back. It replaces the three manual phase clocks and `Reg_Write` switch, and sits between the command source (switch debouncer or test driver) and the datapath top.

## Interface
Parameters:
- `CNT_W`, 8, width of the completed-operation counter

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept a command this cycle
- `cmd_op`  in  4  ALU operation code
- `cmd_addr_a` / `cmd_addr_b`  in  5  read addresses
- `cmd_waddr`  in  5  write-back address
- `cmd_wb`  in  1  1 = write result back
- `step`  in  1  advance enable (present only with `SEQ_STEP_EN`)
- `ALU_OP`  out  4  latched op, held stable for the whole operation
- `R_Addr_A` / `R_Addr_B` / `W_Addr`  out  5  latched addresses, held stable
- `rr_en`  out  1  strobe: load operand registers A/B
- `f_en`  out  1  strobe: load result F and flags FR
- `wb_en`  out  1  strobe: register-file write (drives `Reg_Write`)
- `busy`  out  1  operation in flight (state != IDLE)
- `done`  out  1  one-cycle pulse at operation completion
- `op_cnt`  out  `CNT_W`  completed operations, wraps

## Operation
- States: IDLE, RR, EX, WB. 2-bit encoding 0..3.
- `cmd_ready` = state is IDLE or WB. A command is accepted on a rising edge with `cmd_valid && cmd_ready`.
- On accept: latch `cmd_op`, `cmd_addr_a`, `cmd_addr_b`, `cmd_waddr` and `cmd_wb` into the output/internal registers. Next state is RR.
- RR: `rr_en`=1, then go to EX.
- EX: `f_en`=1, then go to WB.
- WB: `done`=1 and `op_cnt`+1.
  - `wb_en` = latched `cmd_wb && W_Addr != 0`. Register 0 is never written.
  - Next state is RR if a command is accepted this cycle, else IDLE.
- Strobes are decoded from the registered state and are mutually exclusive. At most one strobe is high in any cycle.
- Latched fields change only on accept. Outside accept they hold their last value, including in IDLE.
- `op_cnt` wraps from 2^`CNT_W`-1 to 0.

## Timing
- Reset values: state IDLE; `ALU_OP`, `R_Addr_A`, `R_Addr_B`, `W_Addr`, latched wb flag and `op_cnt` are 0; `rr_en`, `f_en`, `wb_en`, `busy`, `done` are 0. `cmd_ready` is 1 once reset releases.
- Accept at edge N:
  - `rr_en` is high in cycle N+1.
  - `f_en` is high in cycle N+2.
  - `wb_en` and `done` are high in cycle N+3.
  - Without back-to-back: `cmd_ready` stays high, state IDLE, from N+4.
- Back-to-back accept in WB gives a sustained throughput of one op per 3 cycles.
- During the WB cycle of a back-to-back accept, `done` and `wb_en` refer to the old op. The new fields are latched at the end of that cycle, so the write address used by `wb_en` is still the old `W_Addr`.
- `cmd_valid` while in RR or EX is ignored, not queued. The source must hold `cmd_valid` until it sees `cmd_ready`.
- Reset mid-operation: the op is abandoned at once. No further strobes, `done` is not asserted, and `op_cnt` is cleared.

## Configuration
- `SEQ_STEP_EN` defined:
  - The `step` port exists.
  - The transitions out of RR, EX and WB occur only on edges where `step`=1. The state holds otherwise.
  - Each strobe, `done` and the `op_cnt` increment are asserted only in the cycle where `step`=1 in that state. A stage therefore fires exactly once, whatever the dwell time.
  - Accept from IDLE does not need `step`. Accept in WB needs `step`=1.
- `SEQ_STEP_EN` undefined: no `step` port, and every state advances each cycle as above.

## Test plan
- Reset, then op=4'h1, a=3, b=5, waddr=7, wb=1, valid for 1 cycle → `rr_en`, `f_en`, `wb_en`+`done` on N+1/N+2/N+3; `W_Addr`=7; `op_cnt`=1; IDLE at N+4.
- Command with waddr=0, wb=1 → `wb_en` stays 0 throughout; `done`=1 at N+3; `op_cnt` increments.
- `cmd_valid` held high for 3 commands → accepts at N, N+3, N+6; 3 `done` pulses; `op_cnt`=3; `cmd_ready` low during RR/EX.
- Assert `rst` during EX → all strobes drop that cycle; no `wb_en`/`done`; `op_cnt`=0; state IDLE.
- Preload `op_cnt`=255 via 255 ops, then one more → `op_cnt`=0.
- With `SEQ_STEP_EN`, `step` pulsed every 4 cycles → each strobe high for exactly one cycle; `ALU_OP`/addresses stable until `done`.

Source files
------------

// File: rtl/regfile_alu_seq.sv
// regfile_alu_seq: four-phase IDLE/RR/EX/WB command sequencer producing the operand-read, result-latch and write-back strobes
//   inputs : clk, rst (async, active-high), cmd_valid, cmd_op[3:0], cmd_addr_a/b[4:0], cmd_waddr[4:0], cmd_wb, step (SEQ_STEP_EN only)
//   outputs: cmd_ready, ALU_OP[3:0], R_Addr_A/B[4:0], W_Addr[4:0], rr_en, f_en, wb_en, busy, done, op_cnt[CNT_W-1:0]
//   SEQ_STEP_EN: when defined, RR/EX/WB advance (and fire their strobe) only on cycles with step=1
module regfile_alu_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [4:0]       cmd_addr_a,
  input  logic [4:0]       cmd_addr_b,
  input  logic [4:0]       cmd_waddr,
  input  logic             cmd_wb,
`ifdef SEQ_STEP_EN
  input  logic             step,
`endif
  output logic [3:0]       ALU_OP,
  output logic [4:0]       R_Addr_A,
  output logic [4:0]       R_Addr_B,
  output logic [4:0]       W_Addr,
  output logic             rr_en,
  output logic             f_en,
  output logic             wb_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] op_cnt
);
  typedef enum logic [1:0] {IDLE, RR, EX, WB} state_t;
  state_t state, state_nx;
  logic adv, accept, wb_q;
`ifdef SEQ_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif
  // strobes come straight from the registered state, so an async reset kills them in the same cycle
  always_comb begin
    cmd_ready = (state == IDLE) || (state == WB && adv);
    accept    = cmd_valid && cmd_ready;
    rr_en     = state == RR && adv;
    f_en      = state == EX && adv;
    done      = state == WB && adv;
    wb_en     = done && wb_q && W_Addr != 5'd0;
    busy      = state != IDLE;
    state_nx  = state == IDLE ? (accept ? RR : IDLE) :
                state == RR   ? (adv ? EX : RR) :
                state == EX   ? (adv ? WB : EX) :
                                (adv ? (accept ? RR : IDLE) : WB);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ALU_OP   <= '0;
      R_Addr_A <= '0;
      R_Addr_B <= '0;
      W_Addr   <= '0;
      wb_q     <= 1'b0;
    end else if (accept) begin
      ALU_OP   <= cmd_op;
      R_Addr_A <= cmd_addr_a;
      R_Addr_B <= cmd_addr_b;
      W_Addr   <= cmd_waddr;
      wb_q     <= cmd_wb;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst)       op_cnt <= '0;
    else if (done) op_cnt <= op_cnt + 1'b1;
endmodule

// File: tb/tb_regfile_alu_seq.sv
// tb_regfile_alu_seq: scoreboard bench for regfile_alu_seq
module tb_regfile_alu_seq;
  localparam int CNT_W = 8;
  typedef struct {
    logic [3:0] op;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] w;
    logic       wb;
  } cmd_t;
  logic             clk = 1'b0;
  logic             rst, cmd_valid, cmd_wb, step;
  logic [3:0]       cmd_op;
  logic [4:0]       cmd_addr_a, cmd_addr_b, cmd_waddr;
  logic             cmd_ready, rr_en, f_en, wb_en, busy, done;
  logic [3:0]       ALU_OP;
  logic [4:0]       R_Addr_A, R_Addr_B, W_Addr;
  logic [CNT_W-1:0] op_cnt;
  int               checks = 0, errors = 0;
  cmd_t             q[$];
  int               mst = 0, exp_cnt = 0, nacc, ncyc;
  logic             last_acc;

  regfile_alu_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
    .cmd_waddr(cmd_waddr), .cmd_wb(cmd_wb),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .ALU_OP(ALU_OP), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr),
    .rr_en(rr_en), .f_en(f_en), .wb_en(wb_en), .busy(busy), .done(done), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // checks the current cycle against the model, then advances one clock and the model with it
  task automatic cyc();
    logic adv, acc, inwb;
    cmd_t e;
`ifdef SEQ_STEP_EN
    adv = step;
`else
    adv = 1'b1;
`endif
    inwb = mst == 3;
    chk("cmd_ready", cmd_ready, mst == 0 || (inwb && adv));
    chk("rr_en", rr_en, mst == 1 && adv);
    chk("f_en", f_en, mst == 2 && adv);
    chk("done", done, inwb && adv);
    chk("busy", busy, mst != 0);
    chk("op_cnt", op_cnt, exp_cnt);
    if (mst != 0) begin
      if (q.size() == 0) begin
        errors++;
        $error("FAIL scoreboard empty while busy");
      end else begin
        e = q[0];
        chk("ALU_OP", ALU_OP, e.op);
        chk("R_Addr_A", R_Addr_A, e.a);
        chk("R_Addr_B", R_Addr_B, e.b);
        chk("W_Addr", W_Addr, e.w);
        chk("wb_en", wb_en, inwb && adv && e.wb && e.w != 5'd0);
      end
    end else chk("wb_en_idle", wb_en, 0);
    acc = cmd_valid && (mst == 0 || (inwb && adv));
    last_acc = acc;
    @(posedge clk);
    #1;
    if (inwb && adv) begin
      void'(q.pop_front());
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    end
    if (acc) q.push_back('{cmd_op, cmd_addr_a, cmd_addr_b, cmd_waddr, cmd_wb});
    mst = mst == 0 ? (acc ? 1 : 0) :
          mst == 1 ? (adv ? 2 : 1) :
          mst == 2 ? (adv ? 3 : 2) :
                     (adv ? (acc ? 1 : 0) : 3);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] w, input logic wb);
    cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_waddr = w; cmd_wb = wb;
    cmd_valid = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 8 && !last_acc; i++) cyc();
    chk("send_accepted", last_acc, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; step = 1'b1;
    cmd_op = '0; cmd_addr_a = '0; cmd_addr_b = '0; cmd_waddr = '0; cmd_wb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ALU_OP", ALU_OP, 0);
    chk("rst_W_Addr", W_Addr, 0);
    chk("rst_strobes", {rr_en, f_en, wb_en, done, busy}, 0);
    chk("rst_op_cnt", op_cnt, 0);
    rst = 1'b0;
    chk("ready_after_rst", cmd_ready, 1);
    send(4'h1, 5'd3, 5'd5, 5'd7, 1'b1);
    idle(4);
    chk("hold_W_Addr", W_Addr, 7);
    chk("op_cnt_one", op_cnt, 1);
    send(4'h2, 5'd1, 5'd2, 5'd0, 1'b1);
    idle(4);
    chk("op_cnt_two", op_cnt, 2);
    send(4'h3, 5'd4, 5'd6, 5'd9, 1'b0);
    idle(4);
    cmd_valid = 1'b1; nacc = 0; ncyc = 0;
    while (nacc < 3 && ncyc < 20) begin
      cmd_op = 4'(nacc + 8); cmd_addr_a = 5'(nacc + 10); cmd_addr_b = 5'(nacc + 20); cmd_waddr = 5'(nacc + 1); cmd_wb = 1'b1;
      cyc();
      ncyc++;
      if (last_acc) nacc++;
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", nacc, 3);
    chk("b2b_cycles", ncyc, 7);
    idle(4);
    chk("op_cnt_b2b", op_cnt, 6);
    send(4'h5, 5'd1, 5'd1, 5'd2, 1'b1);
    cyc();
    chk("in_ex", f_en, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {rr_en, f_en, wb_en, done, busy}, 0);
    chk("rst_mid_op_cnt", op_cnt, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    mst = 0; q.delete(); exp_cnt = 0;
    #1 rst = 1'b0;
    idle(4);
    cmd_valid = 1'b1; nacc = 0; ncyc = 0;
    while (nacc < (1 << CNT_W) && ncyc < 4 * (1 << CNT_W) + 10) begin
      cmd_op = 4'($urandom); cmd_addr_a = 5'($urandom); cmd_addr_b = 5'($urandom);
      cmd_waddr = 5'($urandom); cmd_wb = 1'($urandom);
      cyc();
      ncyc++;
      if (last_acc) nacc++;
    end
    cmd_valid = 1'b0;
    idle(4);
    chk("op_cnt_wrap", op_cnt, 0);
`ifdef SEQ_STEP_EN
    step = 1'b0;
    send(4'hA, 5'd11, 5'd12, 5'd13, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step = (i % 4 == 3);
      cyc();
    end
    step = 1'b1;
    idle(3);
    chk("step_op_cnt", op_cnt, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
